xilly_loopback_chan: RTL and testbench

//  Parametrised Xillybus stream channel: one write stream (host->FPGA) looped back to one read stream (FPGA->host)

---
 rtl/xilly_pkg.sv | 16 +
 rtl/xilly_sdp_ram.sv | 42 ++++
 rtl/xilly_loopback_chan.sv | 170 +++++++++++++++++
 tb/tb_xilly_loopback_chan.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/xilly_pkg.sv
// Shared definitions for the Xillybus loopback channel: stream mode encoding
// and the check on the stream word width.
package xilly_pkg;

   // Source of read data: the FIFO contents or a free-running counter.
   typedef enum logic {
      MODE_LOOPBACK = 1'b0,
      MODE_PATTERN  = 1'b1
   } mode_e;

   // The xillybus core only offers 8-, 16- and 32-bit stream interfaces.
   function automatic bit data_w_legal(input int w);
      return (w == 8) || (w == 16) || (w == 32);
   endfunction

endpackage

// File: rtl/xilly_sdp_ram.sv
// Simple dual-port RAM: one write port, one read port with an output register.
// The storage array has no reset so it can map onto block RAM.
module xilly_sdp_ram #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 9
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re,
   input  logic              clr,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [2**ADDR_W];
   logic [DATA_W-1:0] rdata_q;

   // Write port.
   // NOTE: the array is deliberately left out of reset; a reset on storage blocks RAM inference.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // Registered read port; clr zeroes the visible word on a channel flush.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata_q <= '0;
      end else if (clr) begin
         rdata_q <= '0;
      end else if (re) begin
         rdata_q <= mem[raddr];
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/xilly_loopback_chan.sv
// Xillybus loopback channel: host write stream returned on the read stream
// through a FIFO, with EOF on writer close, occupancy, sticky error flags and
// a counter-pattern source. Clocked on bus_clk beside the xillybus core.
module xilly_loopback_chan
   import xilly_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 9
) (
   input  logic              bus_clk,
   input  logic              bus_rst_n,
   input  logic              user_w_wren,
   input  logic [DATA_W-1:0] user_w_data,
   output logic              user_w_full,
   input  logic              user_w_open,
   input  logic              user_r_rden,
   output logic [DATA_W-1:0] user_r_data,
   output logic              user_r_empty,
   output logic              user_r_eof,
   input  logic              user_r_open,
   input  logic              mode_pattern,
   output logic [ADDR_W:0]   fill_level,
   output logic              ovf_err,
   output logic              udf_err
);

   localparam int DEPTH = 2**ADDR_W;

   if (!data_w_legal(DATA_W)) begin : g_bad_data_w
      $error("xilly_loopback_chan: DATA_W must be 8, 16 or 32");
   end

   mode_e             mode_q, mode_d;
   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic              full_q, full_d, empty_q, empty_d, eof_q, eof_d;
   logic              ovf_q, ovf_d, udf_q, udf_d;
   logic              close_q, close_d, w_open_q, w_open_d;
   logic [DATA_W-1:0] pat_cnt_q, pat_cnt_d, pat_data_q, pat_data_d;
   logic              flush, is_pat, wr_ok, rd_ok, pat_rd;
   logic [DATA_W-1:0] ram_rdata;

   // Next-state: accept/reject strobes against the pre-edge full/empty flags,
   // track writer close for EOF, and let a flush override everything.
   // NOTE: every _d gets its hold value first, so no path can infer a latch.
   always_comb begin
      // NOTE: combinational logic uses blocking '='; only the state register uses '<='.
      flush  = !user_w_open && !user_r_open;
      is_pat = (mode_q == MODE_PATTERN);
      wr_ok  = !flush && !is_pat && user_w_wren && !full_q;
      rd_ok  = !flush && !is_pat && user_r_rden && !empty_q;
      pat_rd = !flush && is_pat && user_r_rden && !empty_q;

      mode_d     = mode_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      ovf_d      = ovf_q;
      udf_d      = udf_q;
      close_d    = close_q;
      w_open_d   = user_w_open;
      pat_cnt_d  = pat_cnt_q;
      pat_data_d = pat_data_q;

      // Pointers wrap naturally at DEPTH-1 -> 0 through their width.
      if (wr_ok) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      if (rd_ok) rd_ptr_d = rd_ptr_q + ADDR_W'(1);

      case ({wr_ok, rd_ok})
         2'b10:   count_d = count_q + (ADDR_W+1)'(1);
         2'b01:   count_d = count_q - (ADDR_W+1)'(1);
         default: count_d = count_q;
      endcase

      if (!flush && !is_pat && user_w_wren && full_q)  ovf_d = 1'b1;
      if (!flush && !is_pat && user_r_rden && empty_q) udf_d = 1'b1;

      // Writer closing under an open reader arms EOF; a writer reopen disarms it.
      if (w_open_q && !user_w_open && user_r_open) begin
         close_d = 1'b1;
      end else if (!w_open_q && user_w_open) begin
         close_d = 1'b0;
      end

      if (pat_rd) begin
         pat_data_d = pat_cnt_q;
         pat_cnt_d  = pat_cnt_q + DATA_W'(1);
      end

      full_d  = !is_pat && (count_d == (ADDR_W+1)'(DEPTH));
      empty_d = is_pat ? !user_r_open : (count_d == '0);
      eof_d   = !is_pat && close_d && (count_d == '0);

      // Both ends closed: return to reset state and pick up the new mode.
      if (flush) begin
         mode_d     = mode_e'(mode_pattern);
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         count_d    = '0;
         full_d     = 1'b0;
         empty_d    = 1'b1;
         eof_d      = 1'b0;
         ovf_d      = 1'b0;
         udf_d      = 1'b0;
         close_d    = 1'b0;
         w_open_d   = 1'b0;
         pat_cnt_d  = '0;
         pat_data_d = '0;
      end
   end

   // Channel state register.
   always_ff @(posedge bus_clk or negedge bus_rst_n) begin
      if (!bus_rst_n) begin
         mode_q     <= MODE_LOOPBACK;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         full_q     <= 1'b0;
         empty_q    <= 1'b1;
         eof_q      <= 1'b0;
         ovf_q      <= 1'b0;
         udf_q      <= 1'b0;
         close_q    <= 1'b0;
         w_open_q   <= 1'b0;
         pat_cnt_q  <= '0;
         pat_data_q <= '0;
      end else begin
         mode_q     <= mode_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         full_q     <= full_d;
         empty_q    <= empty_d;
         eof_q      <= eof_d;
         ovf_q      <= ovf_d;
         udf_q      <= udf_d;
         close_q    <= close_d;
         w_open_q   <= w_open_d;
         pat_cnt_q  <= pat_cnt_d;
         pat_data_q <= pat_data_d;
      end
   end

   // A read only occurs with count >= 1 and a write only with count < DEPTH,
   // so the two ports never touch the same address on one edge.
   xilly_sdp_ram #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk   (bus_clk),
      .rst_n (bus_rst_n),
      .we    (wr_ok),
      .waddr (wr_ptr_q),
      .wdata (user_w_data),
      .re    (rd_ok),
      .clr   (flush),
      .raddr (rd_ptr_q),
      .rdata (ram_rdata)
   );

   assign user_r_data  = (mode_q == MODE_PATTERN) ? pat_data_q : ram_rdata;
   assign user_w_full  = full_q;
   assign user_r_empty = empty_q;
   assign user_r_eof   = eof_q;
   assign fill_level   = count_q;
   assign ovf_err      = ovf_q;
   assign udf_err      = udf_q;

endmodule

// File: tb/tb_xilly_loopback_chan.sv
// Bench for xilly_loopback_chan: queue-based reference model, read-data
// scoreboard and per-cycle status comparison. Small FIFO and 8-bit words so
// full, overflow and pattern wrap are reached quickly.
module tb_xilly_loopback_chan;

   localparam int DATA_W = 8;
   localparam int ADDR_W = 2;
   localparam int DEPTH  = 4;

   logic              bus_clk = 1'b0;
   logic              bus_rst_n = 1'b0;
   logic              user_w_wren = 1'b0;
   logic [DATA_W-1:0] user_w_data = '0;
   logic              user_w_full;
   logic              user_w_open = 1'b0;
   logic              user_r_rden = 1'b0;
   logic [DATA_W-1:0] user_r_data;
   logic              user_r_empty;
   logic              user_r_eof;
   logic              user_r_open = 1'b0;
   logic              mode_pattern = 1'b0;
   logic [ADDR_W:0]   fill_level;
   logic              ovf_err;
   logic              udf_err;

   xilly_loopback_chan #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .bus_clk      (bus_clk),
      .bus_rst_n    (bus_rst_n),
      .user_w_wren  (user_w_wren),
      .user_w_data  (user_w_data),
      .user_w_full  (user_w_full),
      .user_w_open  (user_w_open),
      .user_r_rden  (user_r_rden),
      .user_r_data  (user_r_data),
      .user_r_empty (user_r_empty),
      .user_r_eof   (user_r_eof),
      .user_r_open  (user_r_open),
      .mode_pattern (mode_pattern),
      .fill_level   (fill_level),
      .ovf_err      (ovf_err),
      .udf_err      (udf_err)
   );

   always #5 bus_clk = ~bus_clk;

   int n_vec = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: stored words as a queue plus the channel's flags.
   logic [DATA_W-1:0] m_fifo[$];
   logic [DATA_W-1:0] sb[$];
   logic [DATA_W-1:0] m_pcnt;
   bit m_pat, m_empty, m_ovf, m_udf, m_close, m_prev_wopen;

   function automatic void model_reset(input bit pat);
      m_fifo.delete();
      sb.delete();
      m_pat        = pat;
      m_empty      = 1'b1;
      m_ovf        = 1'b0;
      m_udf        = 1'b0;
      m_close      = 1'b0;
      m_prev_wopen = 1'b0;
      m_pcnt       = '0;
   endfunction

   // Model update on every active edge from the inputs presented to it.
   initial begin
      bit pre_empty, pre_full;
      model_reset(1'b0);
      forever begin
         @(posedge bus_clk);
         if (!bus_rst_n) begin
            model_reset(1'b0);
         end else if (!user_w_open && !user_r_open) begin
            model_reset(mode_pattern);
         end else begin
            pre_empty = m_empty;
            pre_full  = !m_pat && (m_fifo.size() == DEPTH);
            if (m_pat) begin
               if (user_r_rden && !pre_empty) begin
                  sb.push_back(m_pcnt);
                  m_pcnt = m_pcnt + 8'd1;
               end
               m_empty = !user_r_open;
            end else begin
               if (user_r_rden) begin
                  if (pre_empty) m_udf = 1'b1;
                  else sb.push_back(m_fifo.pop_front());
               end
               if (user_w_wren) begin
                  if (pre_full) m_ovf = 1'b1;
                  else m_fifo.push_back(user_w_data);
               end
               m_empty = (m_fifo.size() == 0);
            end
            if (m_prev_wopen && !user_w_open && user_r_open) m_close = 1'b1;
            else if (!m_prev_wopen && user_w_open) m_close = 1'b0;
            m_prev_wopen = user_w_open;
         end
      end
   end

   // Monitor: a read strobe accepted by the DUT presents a word one cycle
   // later; pop the scoreboard for it and compare status every cycle.
   initial begin
      bit dut_fire;
      forever begin
         @(posedge bus_clk);
         dut_fire = bus_rst_n && (user_w_open || user_r_open) && user_r_rden && !user_r_empty;
         @(negedge bus_clk);
         if (!bus_rst_n) continue;
         if (dut_fire) begin
            if (sb.size() == 0) check("sb_underrun", 32'(1), 32'(0));
            else check("rd_data", 32'(user_r_data), 32'(sb.pop_front()));
         end
         check("fill_level", 32'(fill_level), 32'(m_fifo.size()));
         check("full", 32'(user_w_full), 32'(!m_pat && m_fifo.size() == DEPTH));
         check("empty", 32'(user_r_empty), 32'(m_empty));
         check("eof", 32'(user_r_eof), 32'(!m_pat && m_close && m_fifo.size() == 0));
         check("ovf_err", 32'(ovf_err), 32'(m_ovf));
         check("udf_err", 32'(udf_err), 32'(m_udf));
      end
   end

   task automatic drive(input bit wr, input logic [DATA_W-1:0] d, input bit rd);
      @(negedge bus_clk);
      user_w_wren = wr;
      user_w_data = d;
      user_r_rden = rd;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b0);
   endtask

   task automatic flush_to(input bit pat, input bit w_open, input bit r_open);
      @(negedge bus_clk);
      user_w_wren  = 1'b0;
      user_r_rden  = 1'b0;
      user_w_open  = 1'b0;
      user_r_open  = 1'b0;
      mode_pattern = pat;
      @(negedge bus_clk);
      user_w_open = w_open;
      user_r_open = r_open;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_fill"}, 32'(fill_level), 32'(0));
      check({tag, "_full"}, 32'(user_w_full), 32'(0));
      check({tag, "_empty"}, 32'(user_r_empty), 32'(1));
      check({tag, "_data"}, 32'(user_r_data), 32'(0));
      check({tag, "_eof"}, 32'(user_r_eof), 32'(0));
      check({tag, "_ovf"}, 32'(ovf_err), 32'(0));
      check({tag, "_udf"}, 32'(udf_err), 32'(0));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bit ready;

      // Reset state.
      repeat (2) @(negedge bus_clk);
      check_reset_outputs("reset");
      bus_rst_n   = 1'b1;
      user_w_open = 1'b1;
      user_r_open = 1'b1;
      idle(2);

      // Basic loopback.
      drive(1'b1, 8'h11, 1'b0);
      drive(1'b1, 8'h22, 1'b0);
      drive(1'b1, 8'h33, 1'b0);
      for (int i = 0; i < 3; i++) drive(1'b0, '0, 1'b1);
      idle(2);

      // Fill past full: fifth word dropped, overflow flagged, four read back.
      for (int i = 1; i <= 5; i++) drive(1'b1, 8'(i), 1'b0);
      for (int i = 0; i < 4; i++) drive(1'b0, '0, 1'b1);
      idle(2);

      // Full FIFO with simultaneous write and read.
      for (int i = 0; i < 4; i++) drive(1'b1, 8'(8'hA0 + i), 1'b0);
      drive(1'b1, 8'hEE, 1'b1);
      idle(1);
      for (int i = 0; i < 3; i++) drive(1'b0, '0, 1'b1);
      idle(1);

      // EOF after writer close once drained; cleared by writer reopen.
      flush_to(1'b0, 1'b1, 1'b1);
      drive(1'b1, 8'h5A, 1'b0);
      drive(1'b1, 8'hA5, 1'b0);
      @(negedge bus_clk);
      user_w_wren = 1'b0;
      user_w_open = 1'b0;
      idle(2);
      drive(1'b0, '0, 1'b1);
      drive(1'b0, '0, 1'b1);
      idle(2);
      @(negedge bus_clk);
      user_w_open = 1'b1;
      idle(2);

      // Counter pattern mode, run past the 8-bit wrap; writes are discarded.
      flush_to(1'b1, 1'b0, 1'b1);
      ready = 1'b0;
      for (int i = 0; i < 10 && !ready; i++) begin
         @(negedge bus_clk);
         if (!user_r_empty) ready = 1'b1;
      end
      check("pattern_ready", 32'(ready), 32'(1));
      for (int i = 0; i < 300; i++) begin
         drive(($urandom_range(0, 99) < 20), 8'($urandom), ($urandom_range(0, 99) < 90));
      end
      idle(2);

      // Randomised loopback traffic with occasional writer close/reopen.
      flush_to(1'b0, 1'b1, 1'b1);
      for (int i = 0; i < 400; i++) begin
         @(negedge bus_clk);
         user_w_wren = ($urandom_range(0, 99) < 45);
         user_w_data = 8'($urandom);
         user_r_rden = ($urandom_range(0, 99) < 40);
         if ($urandom_range(0, 99) < 4) user_w_open = !user_w_open;
      end
      @(negedge bus_clk);
      user_w_wren = 1'b0;
      user_r_rden = 1'b0;
      user_w_open = 1'b1;
      for (int i = 0; i < DEPTH; i++) drive(1'b0, '0, 1'b1);
      idle(2);

      // Asynchronous reset mid-stream, then underflow afterwards.
      for (int i = 0; i < 3; i++) drive(1'b1, 8'(8'hC0 + i), 1'b0);
      drive(1'b0, '0, 1'b1);
      @(negedge bus_clk);
      user_r_rden = 1'b0;
      #2;
      bus_rst_n = 1'b0;
      model_reset(1'b0);
      #1;
      check_reset_outputs("async_rst");
      @(negedge bus_clk);
      bus_rst_n = 1'b1;
      idle(1);
      drive(1'b0, '0, 1'b1);
      idle(2);
      check("udf_after_rst", 32'(udf_err), 32'(1));

      idle(2);
      check("sb_drained", 32'(sb.size()), 32'(0));
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
